// File: rtl/n25q_prog_seq.sv
// n25q_prog_seq: command sequencer for the N25Q byte engine.
// Takes one operation at a time and turns it into the flash byte stream:
// WRITE ENABLE, then the opcode, address and data, then status polling until
// the device reports ready.
//
// Operations (op_code): 0 page program, 1 subsector erase, 2 sector erase,
// 3 bulk erase.
//
// Ports:
//   ifclk, reset          clock (rising edge), synchronous active-high reset
//   op_valid/op_ready     operation handshake; op_code/op_addr/op_len are latched
//                         when the operation is accepted
//   wr_data/wr_valid      program data source; wr_ready marks a consumed byte
//   busy, done, status    progress; status is meaningful while done=1
//                         (0 ok, 1 poll timeout, 2 bad length, 3 device error)
//   eng_req/eng_txd/      byte request to the SPI engine; eng_last releases csb
//   eng_last              after the byte
//   eng_ack/eng_rxd       byte complete, received byte
//
// Build option: define N25Q_FLAG_STATUS_EN to poll READ FLAG STATUS (0x70) and
// report program/erase failures (status 3, followed by CLEAR FLAG STATUS).
// Without it the sequencer polls READ STATUS (0x05) and never reports status 3.
module n25q_prog_seq #(
  parameter int unsigned CS_GAP        = 4,
  parameter int unsigned POLL_INTERVAL = 256,
  parameter int unsigned MAX_POLLS     = 65535
) (
  input  logic        ifclk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  input  logic [8:0]  op_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic        eng_req,
  output logic [7:0]  eng_txd,
  output logic        eng_last,
  input  logic        eng_ack,
  input  logic [7:0]  eng_rxd
);

  localparam logic [7:0] OpWren    = 8'h06;
  localparam logic [7:0] OpClrFlag = 8'h50;
`ifdef N25Q_FLAG_STATUS_EN
  localparam logic [7:0] OpPoll    = 8'h70;
`else
  localparam logic [7:0] OpPoll    = 8'h05;
`endif

  localparam logic [1:0] StatOk      = 2'd0;
  localparam logic [1:0] StatTimeout = 2'd1;
  localparam logic [1:0] StatBadLen  = 2'd2;
  localparam logic [1:0] StatDevErr  = 2'd3;

  localparam logic [15:0] GapLoad      = 16'(CS_GAP);
  localparam logic [15:0] IntervalLoad = 16'(POLL_INTERVAL);

  typedef enum logic [3:0] {
    StIdle, StCheck, StWren, StGap1, StCmd, StAddr, StData, StGap2,
    StPollCmd, StPollRd, StPollWait, StClrFlag, StGap3, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [8:0]  idx_q, idx_d;     // address byte / data byte index
  logic [15:0] cnt_q, cnt_d;     // shared gap / poll interval down-counter
  logic [15:0] poll_q, poll_d;   // completed polls, saturating
  logic [1:0]  status_q, status_d;

  logic        dev_ready, dev_err;
  logic        unused_rxd;

`ifdef N25Q_FLAG_STATUS_EN
  assign dev_ready  = eng_rxd[7];
  assign dev_err    = eng_rxd[5] | eng_rxd[4];
  assign unused_rxd = ^{eng_rxd[6], eng_rxd[3:0]};
`else
  assign dev_ready  = ~eng_rxd[0];
  assign dev_err    = 1'b0;
  assign unused_rxd = ^eng_rxd[7:1];
`endif

  logic        is_prog, is_bulk, len_bad, data_last;
  logic [7:0]  cmd_byte, addr_byte;
  logic [15:0] poll_inc;

  assign is_prog   = (code_q == 2'd0);
  assign is_bulk   = (code_q == 2'd3);
  // A program must stay inside one 256-byte page.
  assign len_bad   = (len_q == 9'd0) || (len_q > 9'd256) ||
                     (({2'b00, addr_q[7:0]} + {1'b0, len_q}) > 10'd256);
  assign data_last = (idx_q == (len_q - 9'd1));
  assign poll_inc  = (poll_q == 16'hFFFF) ? poll_q : (poll_q + 16'd1);

  always_comb begin
    unique case (code_q)
      2'd0:    cmd_byte = 8'h02;
      2'd1:    cmd_byte = 8'h20;
      2'd2:    cmd_byte = 8'hD8;
      default: cmd_byte = 8'hC7;
    endcase
  end

  always_comb begin
    unique case (idx_q[1:0])
      2'd0:    addr_byte = addr_q[23:16];
      2'd1:    addr_byte = addr_q[15:8];
      default: addr_byte = addr_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    addr_d   = addr_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    poll_d   = poll_q;
    status_d = status_q;
    op_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    wr_ready = 1'b0;
    eng_req  = 1'b0;
    eng_txd  = 8'h00;
    eng_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        op_ready = 1'b1;
        if (op_valid) begin
          code_d   = op_code;
          addr_d   = op_addr;
          len_d    = op_len;
          idx_d    = '0;
          poll_d   = '0;
          status_d = StatOk;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (is_prog && len_bad) begin
          status_d = StatBadLen;
          state_d  = StDone;
        end else begin
          state_d = StWren;
        end
      end
      StWren: begin
        eng_req  = 1'b1;
        eng_txd  = OpWren;
        eng_last = 1'b1;
        if (eng_ack) begin
          cnt_d   = GapLoad;
          state_d = StGap1;
        end
      end
      StGap1: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StCmd;
      end
      StCmd: begin
        eng_req  = 1'b1;
        eng_txd  = cmd_byte;
        eng_last = is_bulk;
        if (eng_ack) begin
          if (is_bulk) begin
            cnt_d   = GapLoad;
            state_d = StGap2;
          end else begin
            idx_d   = '0;
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        eng_req  = 1'b1;
        eng_txd  = addr_byte;
        eng_last = !is_prog && (idx_q[1:0] == 2'd2);
        if (eng_ack) begin
          if (idx_q[1:0] == 2'd2) begin
            idx_d = '0;
            if (is_prog) begin
              state_d = StData;
            end else begin
              cnt_d   = GapLoad;
              state_d = StGap2;
            end
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
      StData: begin
        // An empty source simply withholds the request; csb stays low.
        eng_req  = wr_valid;
        eng_txd  = wr_data;
        eng_last = wr_valid && data_last;
        wr_ready = wr_valid && eng_ack;
        if (wr_valid && eng_ack) begin
          if (data_last) begin
            cnt_d   = GapLoad;
            state_d = StGap2;
          end else begin
            idx_d = idx_q + 9'd1;
          end
        end
      end
      StGap2: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StPollCmd;
      end
      StPollCmd: begin
        eng_req = 1'b1;
        eng_txd = OpPoll;
        if (eng_ack) state_d = StPollRd;
      end
      StPollRd: begin
        eng_req  = 1'b1;
        eng_txd  = 8'h00;
        eng_last = 1'b1;
        if (eng_ack) begin
          poll_d = poll_inc;
          if (dev_ready) begin
            if (dev_err) begin
              status_d = StatDevErr;
              state_d  = StClrFlag;
            end else begin
              status_d = StatOk;
              state_d  = StDone;
            end
          end else if (32'(poll_inc) >= MAX_POLLS) begin
            status_d = StatTimeout;
            state_d  = StDone;
          end else begin
            cnt_d   = IntervalLoad;
            state_d = StPollWait;
          end
        end
      end
      StPollWait: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StPollCmd;
      end
      StClrFlag: begin
        eng_req  = 1'b1;
        eng_txd  = OpClrFlag;
        eng_last = 1'b1;
        if (eng_ack) begin
          cnt_d   = GapLoad;
          state_d = StGap3;
        end
      end
      StGap3: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign status = status_q;

  always_ff @(posedge ifclk) begin
    if (reset) begin
      state_q  <= StIdle;
      code_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      poll_q   <= '0;
      status_q <= StatOk;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      poll_q   <= poll_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_n25q_prog_seq.sv
// Self-checking bench for n25q_prog_seq. An engine model acks each byte three
// cycles after the request and checks it against a queue of expected
// {eng_last, byte} pairs; poll responses come from a second queue.
module tb_n25q_prog_seq;

  localparam int unsigned CsGap        = 4;
  localparam int unsigned PollInterval = 16;
  localparam int unsigned MaxPolls     = 3;
  localparam int          AckLat       = 3;
  localparam int          Budget       = 3000;
`ifdef N25Q_FLAG_STATUS_EN
  localparam logic [7:0] PollOp = 8'h70;
  localparam logic [7:0] Rdy    = 8'h80;
  localparam logic [7:0] Bsy    = 8'h00;
`else
  localparam logic [7:0] PollOp = 8'h05;
  localparam logic [7:0] Rdy    = 8'h00;
  localparam logic [7:0] Bsy    = 8'h03;
`endif

  logic        ifclk;
  logic        reset;
  logic        op_valid, op_ready;
  logic [1:0]  op_code;
  logic [23:0] op_addr;
  logic [8:0]  op_len;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic        busy, done;
  logic [1:0]  status;
  logic        eng_req, eng_last, eng_ack;
  logic [7:0]  eng_txd, eng_rxd;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [8:0] exp_q[$];      // {last, byte}
  logic [7:0] poll_q[$];
  logic [7:0] poll_default;
  int         poll_cmd_t[$];
  int         poll_rd_t[$];
  logic [7:0] data_q[$];
  int         stall_at, stall_len, stall_left, sent;
  bit         stalling;

  n25q_prog_seq #(
    .CS_GAP       (CsGap),
    .POLL_INTERVAL(PollInterval),
    .MAX_POLLS    (MaxPolls)
  ) dut (
    .ifclk   (ifclk),
    .reset   (reset),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_code (op_code),
    .op_addr (op_addr),
    .op_len  (op_len),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .busy    (busy),
    .done    (done),
    .status  (status),
    .eng_req (eng_req),
    .eng_txd (eng_txd),
    .eng_last(eng_last),
    .eng_ack (eng_ack),
    .eng_rxd (eng_rxd)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;
  always @(posedge ifclk) cycle <= cycle + 1;

  function automatic void push_exp(input logic [7:0] b, input logic l);
    exp_q.push_back({l, b});
  endfunction

  function automatic void clear_env();
    exp_q.delete();
    poll_q.delete();
    poll_cmd_t.delete();
    poll_rd_t.delete();
    data_q.delete();
    poll_default = Rdy;
    stall_at     = 0;
    stall_len    = 0;
    sent         = 0;
  endfunction

  // Engine model and scoreboard: compares every acked byte when it completes.
  task automatic engine_model();
    int         wcnt = 0;
    bit         fire;
    bit         prev_poll = 0;
    logic [7:0] txd;
    logic       last;
    logic [8:0] exp;
    forever begin
      @(negedge ifclk);
      fire = 0;
      if (reset || !eng_req || eng_ack) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == AckLat) begin
          fire = 1;
          wcnt = 0;
        end
      end
      txd  = eng_txd;
      last = eng_last;
      @(posedge ifclk);
      #1;
      eng_ack = 1'b0;
      if (fire && !reset) begin
        eng_ack = 1'b1;
        eng_rxd = 8'hFF;
        if (prev_poll && txd == 8'h00 && last) begin
          if (poll_q.size() > 0) eng_rxd = poll_q.pop_front();
          else eng_rxd = poll_default;
          poll_rd_t.push_back(cycle);
        end
        if (!last && txd == PollOp) poll_cmd_t.push_back(cycle);
        prev_poll = (!last && txd == PollOp);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL engine_byte: got %02h last=%0b, required no byte", txd, last);
        end else begin
          exp = exp_q.pop_front();
          if ({last, txd} !== exp) begin
            errors++;
            $display("FAIL engine_byte: got %02h last=%0b, required %02h last=%0b",
                     txd, last, exp[7:0], exp[8]);
          end
        end
      end
    end
  endtask

  // Program data source with an optional stall after stall_at bytes.
  task automatic data_source();
    bit cons;
    forever begin
      @(negedge ifclk);
      cons = wr_valid && wr_ready;
      @(posedge ifclk);
      #1;
      if (cons) begin
        void'(data_q.pop_front());
        sent++;
        if (sent == stall_at) stall_left = stall_len;
      end
      if (stall_left > 0) begin
        stall_left--;
        stalling = 1;
        wr_valid = 1'b0;
      end else begin
        stalling = 0;
        if (data_q.size() > 0) begin
          wr_valid = 1'b1;
          wr_data  = data_q[0];
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
  endtask

  // Issues one operation and waits (bounded) for done; no checking here.
  task automatic run_op(input logic [1:0] code, input logic [23:0] addr, input logic [8:0] len,
                        output bit got, output int lat, output logic [1:0] st,
                        output int reqs, output int stall_bad, output int stall_cyc);
    got = 0; lat = 0; st = 2'd0; reqs = 0; stall_bad = 0; stall_cyc = 0;
    @(negedge ifclk);
    op_valid = 1'b1;
    op_code  = code;
    op_addr  = addr;
    op_len   = len;
    @(posedge ifclk);
    #1;
    op_valid = 1'b0;
    for (int i = 1; i <= Budget && !got; i++) begin
      @(negedge ifclk);
      if (eng_req) reqs++;
      if (stalling) begin
        stall_cyc++;
        if (eng_req || eng_last || done) stall_bad++;
      end
      if (done) begin
        got = 1;
        lat = i;
        st  = status;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge ifclk);
    checks += 8;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_op_ready: got %b, required 1", op_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (status !== 2'd0) begin errors++; $display("FAIL rst_status: got %0d, required 0", status); end
    if (eng_req !== 1'b0) begin errors++; $display("FAIL rst_eng_req: got %b, required 0", eng_req); end
    if (eng_txd !== 8'h00) begin errors++; $display("FAIL rst_eng_txd: got %02h, required 00", eng_txd); end
    if (eng_last !== 1'b0) begin errors++; $display("FAIL rst_eng_last: got %b, required 0", eng_last); end
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b, required 0", wr_ready); end
    reset = 1'b0;
    @(negedge ifclk);
    checks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got op_ready=%b busy=%b, required 1 0", op_ready, busy);
    end
  endtask

  task automatic test_program();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    push_exp(8'h06, 1);
    push_exp(8'h02, 0); push_exp(8'h01, 0); push_exp(8'h23, 0); push_exp(8'h00, 0);
    push_exp(8'h11, 0); push_exp(8'h22, 0); push_exp(8'h33, 0); push_exp(8'h44, 1);
    push_exp(PollOp, 0); push_exp(8'h00, 1);
    data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    poll_q.push_back(Rdy);
    run_op(2'd0, 24'h012300, 9'd4, got, lat, st, reqs, sb, sc);
    checks += 3;
    if (!got) begin errors++; $display("FAIL prog_done: got no done, required done"); end
    if (st !== 2'd0) begin errors++; $display("FAIL prog_status: got %0d, required 0", st); end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL prog_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_page_edge();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    push_exp(8'h06, 1);
    push_exp(8'h02, 0); push_exp(8'h00, 0); push_exp(8'h00, 0); push_exp(8'hF0, 0);
    for (int i = 0; i < 16; i++) begin
      push_exp(8'hA0 + 8'(i), (i == 15));
      data_q.push_back(8'hA0 + 8'(i));
    end
    push_exp(PollOp, 0); push_exp(8'h00, 1);
    run_op(2'd0, 24'h0000F0, 9'd16, got, lat, st, reqs, sb, sc);
    checks += 2;
    if (!got || st !== 2'd0) begin
      errors++; $display("FAIL edge_status: got done=%0b status=%0d, required 1 0", got, st);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL edge_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_length();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    logic [8:0] lens [3];
    lens[0] = 9'd32; lens[1] = 9'd0; lens[2] = 9'd257;
    for (int k = 0; k < 3; k++) begin
      clear_env();
      run_op(2'd0, (k == 2) ? 24'h000000 : 24'h0000F0, lens[k], got, lat, st, reqs, sb, sc);
      checks += 3;
      if (!got || st !== 2'd2) begin
        errors++; $display("FAIL badlen_status[%0d]: got done=%0b status=%0d, required 1 2", k, got, st);
      end
      if (lat > 3) begin
        errors++; $display("FAIL badlen_latency[%0d]: got %0d cycles, required <=3", k, lat);
      end
      if (reqs != 0) begin
        errors++; $display("FAIL badlen_eng_req[%0d]: got %0d req cycles, required 0", k, reqs);
      end
    end
  endtask

  task automatic test_sector_erase();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    push_exp(8'h06, 1);
    push_exp(8'hD8, 0); push_exp(8'h04, 0); push_exp(8'h00, 0); push_exp(8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      push_exp(PollOp, 0); push_exp(8'h00, 1);
    end
    poll_q = '{Bsy, Bsy, Rdy};
    run_op(2'd2, 24'h040000, 9'd0, got, lat, st, reqs, sb, sc);
    checks += 3;
    if (!got || st !== 2'd0) begin
      errors++; $display("FAIL erase_status: got done=%0b status=%0d, required 1 0", got, st);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL erase_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
    if (poll_rd_t.size() != 3 || poll_cmd_t.size() != 3) begin
      errors++; $display("FAIL erase_polls: got %0d reads, required 3", poll_rd_t.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (poll_cmd_t[k] - poll_rd_t[k-1] < int'(PollInterval)) begin
          errors++;
          $display("FAIL erase_poll_gap[%0d]: got %0d cycles, required >=%0d",
                   k, poll_cmd_t[k] - poll_rd_t[k-1], PollInterval);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    poll_default = Bsy;
    push_exp(8'h06, 1);
    push_exp(8'hC7, 1);
    for (int i = 0; i < 3; i++) begin
      push_exp(PollOp, 0); push_exp(8'h00, 1);
    end
    run_op(2'd3, 24'hABCDEF, 9'd0, got, lat, st, reqs, sb, sc);
    checks += 2;
    if (!got || st !== 2'd1) begin
      errors++; $display("FAIL timeout_status: got done=%0b status=%0d, required 1 1", got, st);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    stall_at  = 2;
    stall_len = 20;
    push_exp(8'h06, 1);
    push_exp(8'h02, 0); push_exp(8'h10, 0); push_exp(8'h02, 0); push_exp(8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      push_exp(8'h31 + 8'(i * 3), (i == 7));
      data_q.push_back(8'h31 + 8'(i * 3));
    end
    push_exp(PollOp, 0); push_exp(8'h00, 1);
    run_op(2'd0, 24'h100200, 9'd8, got, lat, st, reqs, sb, sc);
    checks += 4;
    if (sc != 20) begin errors++; $display("FAIL stall_len: got %0d cycles, required 20", sc); end
    if (sb != 0) begin
      errors++; $display("FAIL stall_quiet: got %0d active cycles, required 0", sb);
    end
    if (!got || st !== 2'd0) begin
      errors++; $display("FAIL stall_status: got done=%0b status=%0d, required 1 0", got, st);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int done_seen = 0;
    clear_env();
    push_exp(8'h06, 1);
    push_exp(8'hD8, 0); push_exp(8'h04, 0); push_exp(8'h00, 0); push_exp(8'h00, 1);
    @(negedge ifclk);
    op_valid = 1'b1; op_code = 2'd2; op_addr = 24'h040000; op_len = 9'd0;
    @(posedge ifclk);
    #1;
    op_valid = 1'b0;
    while (exp_q.size() > 3 && n < Budget) begin
      @(negedge ifclk);
      if (done) done_seen++;
      n++;
    end
    checks++;
    if (n >= Budget) begin errors++; $display("FAIL rstmid_reach_addr: got timeout, required ADDR"); end
    @(negedge ifclk);
    reset = 1'b1;
    @(negedge ifclk);
    checks += 2;
    if (eng_req !== 1'b0) begin errors++; $display("FAIL rstmid_eng_req: got %b, required 0", eng_req); end
    if (op_ready !== 1'b1) begin errors++; $display("FAIL rstmid_op_ready: got %b, required 1", op_ready); end
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge ifclk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL rstmid_done: got %0d pulses, required 0", done_seen); end
  endtask

`ifdef N25Q_FLAG_STATUS_EN
  task automatic test_flag_error();
    bit got; int lat, reqs, sb, sc; logic [1:0] st;
    clear_env();
    push_exp(8'h06, 1);
    push_exp(8'hD8, 0); push_exp(8'h01, 0); push_exp(8'h00, 0); push_exp(8'h00, 1);
    push_exp(8'h70, 0); push_exp(8'h00, 1);
    push_exp(8'h50, 1);
    poll_q.push_back(8'hA0);
    run_op(2'd2, 24'h010000, 9'd0, got, lat, st, reqs, sb, sc);
    checks += 2;
    if (!got || st !== 2'd3) begin
      errors++; $display("FAIL flag_status: got done=%0b status=%0d, required 1 3", got, st);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL flag_bytes_left: got %0d unsent, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    op_valid   = 1'b0;
    op_code    = 2'd0;
    op_addr    = 24'h0;
    op_len     = 9'd0;
    wr_data    = 8'h00;
    wr_valid   = 1'b0;
    eng_ack    = 1'b0;
    eng_rxd    = 8'h00;
    stall_left = 0;
    stalling   = 0;
    clear_env();
    fork
      engine_model();
      data_source();
    join_none
    repeat (3) @(negedge ifclk);
    test_reset();
    test_program();
    test_page_edge();
    test_bad_length();
    test_sector_erase();
    test_timeout();
    test_stall();
    test_reset_mid();
`ifdef N25Q_FLAG_STATUS_EN
    test_flag_error();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/n25q_prog_seq.md
Name: n25q_prog_seq

Overview:
- Command sequencer for the N25Q serial flash byte engine.
- Accepts one high-level operation at a time: page program, subsector erase, sector erase or bulk erase.
- Expands it into the required flash byte stream: WRITE ENABLE, then command, 24-bit address and data, then status polling until the device is ready.
- Sits between the host-register/DMA side and the byte-level SPI engine, so software no longer hand-sequences WREN and busy polling.

Parameters:
- CS_GAP, default 4: ifclk cycles of csb-high idle enforced between consecutive flash commands (tSHSL margin); legal range 1..255.
- POLL_INTERVAL, default 256: ifclk cycles waited between status-register polls; legal range 1..65535.
- MAX_POLLS, default 65535: poll attempts allowed before the operation is aborted with a timeout.

Ports:
- ifclk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request.
- op_ready  out  1  high in IDLE only; an operation is accepted on op_valid&&op_ready.
- op_code  in  2  0=page program (0x02), 1=subsector erase (0x20), 2=sector erase (0xD8), 3=bulk erase (0xC7).
- op_addr  in  24  flash byte address; ignored for bulk erase.
- op_len  in  9  program byte count, 1..256; ignored for erase.
- wr_data  in  8  program data byte.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  data byte consumed this cycle (wr_valid&&wr_ready).
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle completion pulse.
- status  out  2  qualified by done: 0=ok, 1=poll timeout, 2=bad length/page cross, 3=device error.
- eng_req  out  1  byte transfer request to the SPI engine.
- eng_txd  out  8  byte to shift out.
- eng_last  out  1  engine raises csb after this byte.
- eng_ack  in  1  one-cycle pulse; the byte has completed.
- eng_rxd  in  8  byte shifted in; valid when eng_ack=1.

Behaviour:
- Reset values:
  - op_ready=1 (state IDLE); busy=0; done=0; status=0.
  - eng_req=0; eng_txd=0; eng_last=0; wr_ready=0.
  - Poll counter and gap counter cleared.
- Reset asserted mid-operation: IDLE on the next edge and eng_req dropped; no done pulse.
- Engine handshake:
  - eng_req, eng_txd and eng_last are held stable until eng_ack.
  - eng_req deasserts in the cycle after eng_ack unless another byte is presented back-to-back in the same command.
- States and transitions:
  - IDLE -> CHECK on accept. op_code, op_addr and op_len are latched at acceptance.
  - CHECK (1 cycle), program only: if op_len==0, op_len>256, or op_addr[7:0]+op_len>256 (page crossing), go to DONE with status=2 and issue no SPI traffic. Otherwise go to WREN.
  - WREN: send 0x06 with eng_last=1 -> GAP1.
  - GAP1: CS_GAP cycles -> CMD.
  - CMD: send the opcode.
    - Bulk erase: eng_last=1 -> GAP2.
    - Otherwise -> ADDR.
  - ADDR: send address bytes A[23:16], A[15:8], A[7:0].
    - Erase: last byte carries eng_last=1 -> GAP2.
    - Program -> DATA.
  - DATA: eng_req is asserted only while wr_valid=1; wr_ready pulses with eng_ack.
    - The byte counter runs 0..op_len-1; eng_last=1 on byte op_len-1 -> GAP2.
    - An empty source stalls with csb held low.
  - GAP2: CS_GAP cycles -> POLL_CMD.
  - POLL_CMD: send the status-read opcode (eng_last=0) -> POLL_RD.
  - POLL_RD: send 0x00 with eng_last=1 and capture eng_rxd at eng_ack.
    - Ready -> DONE with status=0.
    - Poll count==MAX_POLLS -> DONE with status=1.
    - Otherwise -> POLL_WAIT.
  - POLL_WAIT: POLL_INTERVAL cycles -> POLL_CMD.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- op_ready is 0 in every state except IDLE; op_valid in other states is ignored.
- Poll counter: 16 bits, saturating, incremented per completed poll.
- Gap and interval counters: load the parameter value and count down to 0.

Optional Feature:
- Macro N25Q_FLAG_STATUS_EN.
- Defined:
  - Poll uses READ FLAG STATUS 0x70; ready when rxd[7]=1.
  - If ready and (rxd[5] or rxd[4]): status=3.
  - On status=3, an extra CLEAR FLAG STATUS command (0x50, eng_last=1) is issued, then CS_GAP cycles, before DONE.
- Undefined: poll uses READ STATUS 0x05; ready when rxd[0]=0; status=3 is never produced.

Test Plan:
- Program, addr=0x012300, len=4, data 11 22 33 44, engine acks after 3 cycles, first poll returns 0x00 -> engine bytes 06 | 02 01 23 00 11 22 33 44 | 05 00; eng_last on 06, 44, 00; done with status=0.
- Sector erase, addr=0x040000, polls return 0x03, 0x03, 0x00 -> bytes 06 | D8 04 00 00 | three 05/00 pairs each ≥POLL_INTERVAL apart; status=0.
- Program, addr=0x0000F0, len=32 (page cross) and len=0 -> done with status=2 within 3 cycles of acceptance; eng_req never asserted.
- Bulk erase with MAX_POLLS=3, status always 0x01 -> bytes 06 | C7 | 05 00 x3, then done with status=1.
- Program, len=8, wr_valid withheld for 20 cycles after byte 2 -> eng_req low, eng_last low and no done during the stall; completes with the correct 8 bytes.
- Reset pulsed during ADDR -> next cycle eng_req=0, op_ready=1, no done. With N25Q_FLAG_STATUS_EN: flag read 0xA0 -> 0x50 issued, then status=3.
